// File: rtl/gpu_pkg.sv
// gpu_pkg: constants and types shared by the BF16 tensor unit.
//   - tensor opcodes decoded by gpu_core before it raises start
//   - BF16 field widths, exponent bias and special encodings
//   - controller state encoding
//   - small field classification helpers
package gpu_pkg;

    localparam logic [3:0] OP_BF16_MUL = 4'h2;
    localparam logic [3:0] OP_BF16_MAC = 4'h3;

    localparam int BF16_W      = 16;
    localparam int BF16_EXP_W  = 8;
    localparam int BF16_FRAC_W = 7;
    localparam int BF16_BIAS   = 127;

    localparam logic [15:0] BF16_POS_INF = 16'h7F80;
    localparam logic [15:0] BF16_NEG_INF = 16'hFF80;
    localparam logic [15:0] BF16_QNAN    = 16'h7FC0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tu_state_e;

    function automatic logic bf16_is_nan(input logic [BF16_W-1:0] v);
        return (v[14:7] == 8'hFF) && (v[6:0] != 7'h00);
    endfunction

    function automatic logic bf16_is_inf(input logic [BF16_W-1:0] v);
        return (v[14:7] == 8'hFF) && (v[6:0] == 7'h00);
    endfunction

endpackage

// File: rtl/bf16_fma.sv
// bf16_fma: single-lane combinational BF16 multiply / multiply-add.
//   x, y   : multiplicands
//   z      : addend, only consulted when use_z = 1
//   use_z  : 0 -> r = x*y, 1 -> r = x*y + z
//   r      : result, truncated toward zero, subnormals flushed to zero
module bf16_fma
    import gpu_pkg::*;
#(
    parameter logic [15:0] QNAN = BF16_QNAN
) (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] z,
    input  logic        use_z,
    output logic [15:0] r
);

    // Biased exponent of bit 15 of the 16-bit significand product.
    localparam logic signed [10:0] PROD_TOP_ADJ = 11'(BF16_BIAS - 1);

    logic                  sx, sy, sz, sp;
    logic [BF16_EXP_W-1:0] ex, ey, ez;
    logic                  x_zero, y_zero, z_zero, p_zero;
    logic                  x_inf, y_inf, z_inf, any_nan;
    logic [7:0]            mx, my, mz;
    logic [15:0]           mp;
    logic signed [10:0]    ep_top, d;

    assign sx = x[15];
    assign sy = y[15];
    assign sz = z[15];
    assign sp = sx ^ sy;
    assign ex = x[14:7];
    assign ey = y[14:7];
    assign ez = z[14:7];

    // Exponent field 0 is treated as zero regardless of fraction (flush to zero).
    assign x_zero  = (ex == 8'h00);
    assign y_zero  = (ey == 8'h00);
    assign z_zero  = (ez == 8'h00) || !use_z;
    assign p_zero  = x_zero || y_zero;
    assign x_inf   = bf16_is_inf(x);
    assign y_inf   = bf16_is_inf(y);
    assign z_inf   = use_z && bf16_is_inf(z);
    assign any_nan = bf16_is_nan(x) || bf16_is_nan(y) || (use_z && bf16_is_nan(z));

    assign mx = x_zero ? 8'h00 : {1'b1, x[6:0]};
    assign my = y_zero ? 8'h00 : {1'b1, y[6:0]};
    assign mz = z_zero ? 8'h00 : {1'b1, z[6:0]};
    assign mp = 16'(mx) * 16'(my);

    assign ep_top = $signed({3'b000, ex}) + $signed({3'b000, ey}) - PROD_TOP_ADJ;
    assign d      = ep_top - $signed({3'b000, ez});

    logic               pick_p;
    logic [10:0]        d_mag;
    logic [4:0]         sh;
    logic [18:0]        big_f, small_raw, small_f;
    logic [37:0]        small_ext;
    logic               big_s, small_s, res_s;
    logic signed [10:0] e_top_sel, e_res;
    logic [19:0]        diff, sum;
    logic [4:0]         msb;
    logic [6:0]         frac;

    // Both significands sit in a 19-bit field whose bit 18 carries the larger
    // operand's top exponent: 16 significand bits, 2 guard bits and a sticky
    // bit at position 0. Bits shifted out of the smaller operand only ever OR
    // into the sticky, which makes truncation of the sum exact toward zero.
    always_comb begin
        pick_p    = !p_zero && (z_zero || (d >= 11'sd0));
        d_mag     = d[10] ? 11'(-d) : 11'(d);
        sh        = (d_mag > 11'd19) ? 5'd19 : d_mag[4:0];
        big_f     = '0;
        small_raw = '0;
        big_s     = 1'b0;
        small_s   = 1'b0;
        e_top_sel = '0;
        if (pick_p) begin
            big_f     = {mp, 3'b000};
            big_s     = sp;
            small_raw = {mz, 11'b0};
            small_s   = sz;
            e_top_sel = ep_top;
        end else begin
            big_f     = {mz, 11'b0};
            big_s     = sz;
            small_raw = {mp, 3'b000};
            small_s   = sp;
            e_top_sel = $signed({3'b000, ez});
        end
        small_ext = {small_raw, 19'b0} >> sh;
        small_f   = {small_ext[37:20], small_ext[19] | (|small_ext[18:0])};

        diff  = '0;
        sum   = '0;
        res_s = big_s;
        if (big_s == small_s) begin
            sum = {1'b0, big_f} + {1'b0, small_f};
        end else begin
            diff = {1'b0, big_f} - {1'b0, small_f};
            if (diff[19]) begin
                sum   = -diff;
                res_s = small_s;
            end else begin
                sum = diff;
            end
        end

        msb = 5'd0;
        for (int i = 0; i < 20; i++) begin
            if (sum[i]) msb = 5'(i);
        end
        e_res = e_top_sel + $signed({6'b0, msb}) - 11'sd18;
        // Left-justify the leading one to bit 19 and keep the next 7 bits.
        frac  = 7'((sum << (5'd19 - msb)) >> 12);

        r = '0;
        if (any_nan) begin
            r = QNAN;
        end else if ((x_inf && y_zero) || (y_inf && x_zero)) begin
            r = QNAN;
        end else if ((x_inf || y_inf) && z_inf && (sp != sz)) begin
            r = QNAN;
        end else if (x_inf || y_inf) begin
            r = sp ? BF16_NEG_INF : BF16_POS_INF;
        end else if (z_inf) begin
            r = sz ? BF16_NEG_INF : BF16_POS_INF;
        end else if (sum == 20'd0) begin
            // A cancelled or all-zero MAC is +0; a zero product keeps its sign.
            r = use_z ? 16'h0000 : {sp, 15'h0000};
        end else if (e_res < 11'sd1) begin
            r = {res_s, 15'h0000};
        end else if (e_res > 11'sd254) begin
            r = res_s ? BF16_NEG_INF : BF16_POS_INF;
        end else begin
            r = {res_s, e_res[7:0], frac};
        end
    end

endmodule

// File: rtl/bf16_tensor_unit.sv
// bf16_tensor_unit: 4-lane BF16 MUL/MAC responder on the tensor start/done
// handshake. One lane per cycle goes through a shared bf16_fma.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request; accepted in IDLE or DONE, ignored while busy
//   op          : 0 = a*b, 1 = a*b + acc
//   a, b, acc   : packed operands, lane i at [16i+15:16i]
//   busy        : lanes in flight (4 cycles)
//   done        : single-cycle pulse, result valid
//   result      : packed result, held until the next accepted start
module bf16_tensor_unit
    import gpu_pkg::*;
#(
    parameter int          LANES = 4,
    parameter logic [15:0] QNAN  = BF16_QNAN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op,
    input  logic [16*LANES-1:0]   a,
    input  logic [16*LANES-1:0]   b,
    input  logic [16*LANES-1:0]   acc,
    output logic                  busy,
    output logic                  done,
    output logic [16*LANES-1:0]   result
);

    localparam int LANE_W = $clog2(LANES);

    tu_state_e             state_reg, state_next;
    logic [LANE_W-1:0]     lane_reg, lane_next;
    logic                  op_reg;
    logic [16*LANES-1:0]   a_reg, b_reg, acc_reg;
    logic                  accept;
    logic [15:0]           fma_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. DONE accepts a new start so requests can run back-to-back.
    always_comb begin
        state_next = state_reg;
        lane_next  = lane_reg;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                state_next = ST_IDLE;
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                    lane_next  = '0;
                end
            end
            ST_RUN: begin
                lane_next = lane_reg + LANE_W'(1);
                if (lane_reg == LANE_W'(LANES - 1)) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                lane_next  = '0;
            end
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Lane counter and operand latches; operands only move on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_reg <= '0;
            op_reg   <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            acc_reg  <= '0;
        end else begin
            lane_reg <= lane_next;
            if (accept) begin
                op_reg  <= op;
                a_reg   <= a;
                b_reg   <= b;
                acc_reg <= acc;
            end
        end
    end

    bf16_fma #(
        .QNAN (QNAN)
    ) u_fma (
        .x     (a_reg[{lane_reg, 4'b0000} +: 16]),
        .y     (b_reg[{lane_reg, 4'b0000} +: 16]),
        .z     (acc_reg[{lane_reg, 4'b0000} +: 16]),
        .use_z (op_reg),
        .r     (fma_r)
    );

    // One result register per lane, loaded in the cycle its lane is selected.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [15:0] res_lane_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_lane_reg <= '0;
            end else if ((state_reg == ST_RUN) && (lane_reg == LANE_W'(gi))) begin
                res_lane_reg <= fma_r;
            end
        end

        assign result[16*gi +: 16] = res_lane_reg;
    end

endmodule

// File: tb/tb_bf16_tensor_unit.sv
// Bench for bf16_tensor_unit: directed handshake/arithmetic cases plus
// randomized operands checked against an exact-arithmetic reference.
module tb_bf16_tensor_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [63:0] a, b, acc;
    logic        busy, done;
    logic [63:0] result;

    int errors = 0;
    int checks = 0;

    bf16_tensor_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .acc    (acc),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference: form the exact value a*b(+c) as an integer scaled by 2^266,
    // then truncate it to an 8-bit significand and classify the exponent.
    function automatic logic [15:0] ref_fma(input logic [15:0] x, input logic [15:0] y,
                                            input logic [15:0] z, input logic use_z);
        bit x_nan, y_nan, z_nan, x_inf, y_inf, z_inf, x_zero, y_zero, z_zero, sp, neg;
        logic signed [639:0] pv, zv, s;
        logic [639:0] mag;
        int mprod, p, e;
        logic [6:0] frac;
        x_nan  = (x[14:7] == 8'hFF) && (x[6:0] != 7'h0);
        y_nan  = (y[14:7] == 8'hFF) && (y[6:0] != 7'h0);
        x_inf  = (x[14:7] == 8'hFF) && (x[6:0] == 7'h0);
        y_inf  = (y[14:7] == 8'hFF) && (y[6:0] == 7'h0);
        x_zero = (x[14:7] == 8'h00);
        y_zero = (y[14:7] == 8'h00);
        z_nan  = use_z && (z[14:7] == 8'hFF) && (z[6:0] != 7'h0);
        z_inf  = use_z && (z[14:7] == 8'hFF) && (z[6:0] == 7'h0);
        z_zero = !use_z || (z[14:7] == 8'h00);
        sp     = x[15] ^ y[15];
        if (x_nan || y_nan || z_nan) return 16'h7FC0;
        if ((x_inf || y_inf) && (x_zero || y_zero)) return 16'h7FC0;
        if ((x_inf || y_inf) && z_inf) return (sp == z[15]) ? {sp, 8'hFF, 7'h0} : 16'h7FC0;
        if (x_inf || y_inf) return {sp, 8'hFF, 7'h0};
        if (z_inf) return {z[15], 8'hFF, 7'h0};
        pv = '0;
        zv = '0;
        if (!x_zero && !y_zero) begin
            mprod = int'({1'b1, x[6:0]}) * int'({1'b1, y[6:0]});
            pv = 640'(mprod);
            pv = pv << (int'(x[14:7]) + int'(y[14:7]) - 2);
        end
        if (!z_zero) begin
            zv = 640'(int'({1'b1, z[6:0]}));
            zv = zv << (int'(z[14:7]) + 132);
        end
        s = (sp ? -pv : pv) + (z[15] ? -zv : zv);
        if (s == 0) return use_z ? 16'h0000 : {sp, 15'h0};
        neg = (s < 0);
        mag = neg ? -s : s;
        p = 0;
        for (int i = 0; i < 640; i++) if (mag[i]) p = i;
        e = p - 139;
        if (p >= 7) frac = 7'(mag >> (p - 7));
        else        frac = 7'(mag << (7 - p));
        if (e < 1)   return {neg, 15'h0};
        if (e > 254) return {neg, 8'hFF, 7'h0};
        return {neg, 8'(e), frac};
    endfunction

    function automatic logic [63:0] model_vec(input logic o, input logic [63:0] va,
                                              input logic [63:0] vb, input logic [63:0] vc);
        logic [63:0] r;
        for (int i = 0; i < 4; i++)
            r[16*i +: 16] = ref_fma(va[16*i +: 16], vb[16*i +: 16], vc[16*i +: 16], o);
        return r;
    endfunction

    function automatic logic [15:0] rand_bf16();
        logic [15:0] v;
        case ($urandom_range(0, 9))
            0: case ($urandom_range(0, 7))
                   0: v = 16'h0000;
                   1: v = 16'h8000;
                   2: v = 16'h7F80;
                   3: v = 16'hFF80;
                   4: v = 16'h7FC0;
                   5: v = 16'h0001;
                   6: v = 16'h7F7F;
                   default: v = 16'h0080;
               endcase
            1, 2, 3, 4, 5: v = {1'($urandom), 8'($urandom_range(120, 134)), 7'($urandom)};
            default:       v = {1'($urandom), 8'($urandom_range(1, 254)), 7'($urandom)};
        endcase
        return v;
    endfunction

    // Caller sits at a negedge. Start is driven for one cycle; busy/done are
    // checked in each following cycle and the task returns at the negedge of
    // the done cycle. inject = 1..4 re-asserts start with junk in that cycle.
    task automatic do_op(input logic o, input logic [63:0] ta, input logic [63:0] tb,
                         input logic [63:0] tc, input logic [63:0] want,
                         input int inject, input string tag);
        start = 1'b1; op = o; a = ta; b = tb; acc = tc;
        @(negedge clk);
        for (int c = 1; c <= 4; c++) begin
            start = (c == inject);
            if (c == inject) begin
                op = ~o; a = ~ta; b = {$urandom, $urandom}; acc = ~tc;
            end
            check_val({tag, "_busy"}, 64'(busy), 64'd1);
            check_val({tag, "_done_early"}, 64'(done), 64'd0);
            @(negedge clk);
        end
        start = 1'b0;
        check_val({tag, "_done"}, 64'(done), 64'd1);
        check_val({tag, "_busy_off"}, 64'(busy), 64'd0);
        check_val({tag, "_result"}, result, want);
        $display("op %s op=%0d a=%h b=%h acc=%h result=%h want=%h", tag, o, ta, tb, tc, result, want);
    endtask

    initial begin
        logic [63:0] ra, rb, rc, rw;
        logic        ro;

        rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0; acc = '0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_result", result, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(1'b0, 64'h3F80_3FC0_4000_4040, 64'h4040_4000_3FC0_4000, 64'h0,
              64'h4040_4040_4040_40C0, 0, "mul_basic");
        @(negedge clk);
        check_val("done_width", 64'(done), 64'd0);
        do_op(1'b1, 64'h4000_4000_4000_4000, 64'h4040_4040_4040_4040, 64'h3F80_BF80_C0C0_0000,
              64'h40E0_40A0_0000_40C0, 0, "mac_basic");
        @(negedge clk);
        do_op(1'b0, 64'h0001_7F80_7FC1_7F00, 64'h4000_0000_3F80_4000, 64'h0,
              64'h0000_7FC0_7FC0_7F80, 0, "mul_special");
        @(negedge clk);
        do_op(1'b0, 64'hC000_8000_4000_3F80, 64'h4040_4000_C000_3F80, 64'h0,
              64'hC0C0_8000_C080_3F80, 0, "mul_sign");
        @(negedge clk);
        do_op(1'b1, 64'h7F80_3F80_3F80_7F80, 64'h3F80_3F80_3F80_3F80, 64'hFF80_BF80_7F80_7F80,
              64'h7FC0_0000_7F80_7F80, 0, "mac_special");

        // Back-to-back from the DONE cycle, with a start pulsed mid-run.
        do_op(1'b0, 64'h3F80_3FC0_4000_4040, 64'h4040_4000_3FC0_4000, 64'h0,
              64'h4040_4040_4040_40C0, 2, "b2b_ignore");

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 64'h4000_4000_4000_4000; b = 64'h4000_4000_4000_4000;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_done", 64'(done), 64'd0);
        check_val("midrst_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_val("midrst_no_done", 64'(done), 64'd0);
        end
        do_op(1'b1, 64'h4000_4000_4000_4000, 64'h4040_4040_4040_4040, 64'h3F80_BF80_C0C0_0000,
              64'h40E0_40A0_0000_40C0, 0, "after_rst");

        // Result holds while inputs wander without a start.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            op = 1'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
            acc = {$urandom, $urandom};
            check_val("hold_result", result, 64'h40E0_40A0_0000_40C0);
            check_val("hold_done", 64'(done), 64'd0);
        end

        // Randomized operations, mixing idle gaps, back-to-back and ignored starts.
        for (int n = 0; n < 160; n++) begin
            ro = 1'($urandom);
            for (int l = 0; l < 4; l++) begin
                ra[16*l +: 16] = rand_bf16();
                rb[16*l +: 16] = rand_bf16();
                rc[16*l +: 16] = rand_bf16();
                if ($urandom_range(0, 3) == 0)
                    rc[16*l +: 16] = ref_fma(ra[16*l +: 16], rb[16*l +: 16], 16'h0, 1'b0) ^ 16'h8000;
            end
            rw = model_vec(ro, ra, rb, rc);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            do_op(ro, ra, rb, rc, rw, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                  $sformatf("rand%0d", n));
        end

        @(negedge clk);
        check_val("final_done_low", 64'(done), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bf16_tensor_unit.md
Name: bf16_tensor_unit

Overview:
Multi-cycle BF16 SIMD responder to the gpu_core tensor start/done handshake. Serves opcodes 4'h2 (BF16 MUL) and 4'h3 (BF16 MAC) on 4 packed 16-bit lanes of a 64-bit register. Processes one lane per cycle through a single shared FMA datapath. Returns a packed 64-bit result with a one-cycle done pulse, which the core uses to release its PC stall and arbitrate writeback.

Parameters:
LANES, 4, number of 16-bit BF16 lanes per 64-bit operand (fixed; other values unsupported)
QNAN, 16'h7FC0, canonical NaN written for invalid operations

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request pulse; sampled only when the unit is not busy
op  input  1  0 = MUL (a*b), 1 = MAC (a*b + acc)
a  input  64  operand A; lane i = a[16i+15:16i]
b  input  64  operand B; same lane packing as a
acc  input  64  accumulator operand, used only when op=1
busy  output  1  high while lanes are being computed
done  output  1  one-cycle pulse; result is valid in that cycle
result  output  64  packed BF16 result; held until the next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE, lane counter=0, busy=0, done=0, result=64'h0, operand latches=0. Reset during RUN abandons the operation; no done is produced.
- States:
  - IDLE: wait for start.
  - RUN: lane counter 0..3, one lane per cycle.
  - DONE: single cycle.
- Accept rule: start=1 in IDLE or DONE at edge T latches op/a/b/acc and enters RUN with lane=0.
- start while in RUN is ignored. The latched operands are unaffected.
- Timing:
  - busy=1 during cycles T+1..T+4.
  - Lane i is written into result[16i+15:16i] at the end of cycle T+1+i.
  - done=1 and busy=0 in cycle T+5.
  - Total latency is 5 cycles from start to done.
- Upper lanes of result may update during RUN. Consumers read result only on done.
- Back-to-back: start in the DONE cycle is accepted. The next done occurs 5 cycles later, and done never pulses twice consecutively.
- Arithmetic (per lane, inside bf16_fma):
  - Inputs with exp=0 are flushed to signed zero (FTZ).
  - The 8x8 significand product is exact (16 bits).
  - For MAC, the product is aligned against acc using a 2-bit guard margin plus sticky, then added or subtracted.
  - One final normalization truncates to a 7-bit fraction (round toward zero).
  - Output exponent < 1 gives signed zero (FTZ). Exponent > 254 gives ±Inf (0x7F80/0xFF80).
  - Any NaN input, Inf*0, or Inf + (−Inf) gives QNAN.
  - Inf propagates with the correct sign otherwise.
  - An exact-zero MAC sum gives +0 (0x0000). A MUL zero result has sign = sa^sb.

Decomposition:
- gpu_pkg holds:
  - opcode constants OP_BF16_MUL=4'h2 and OP_BF16_MAC=4'h3
  - BF16 field widths and the bias (127)
  - constants BF16_POS_INF, BF16_NEG_INF, BF16_QNAN
  - state encoding for IDLE/RUN/DONE
- Sub-module bf16_fma is purely combinational: inputs x, y, z, use_z; output r (16-bit). It is instantiated once in bf16_tensor_unit and muxed by the lane counter.
- Controller, lane mux and result register live in bf16_tensor_unit.

Test Plan:
- MUL latency: a=64'h3F80_3FC0_4000_4040, b=64'h4040_4000_3FC0_4000, op=0, start at T -> busy high T+1..T+4; done only at T+5; result=64'h4040_4040_4040_40C0 (lanes 3.0, 3.0, 3.0, 6.0).
- MAC: a=4×4000, b=4×4040, acc=64'h3F80_BF80_C0C0_0000, op=1 -> result=64'h40E0_40A0_0000_40C0 (7.0, 5.0, +0, 6.0).
- Specials, MUL: lane a/b pairs (7F00, 4000), (7FC1, 3F80), (7F80, 0000), (0001, 4000) -> lanes 7F80 (overflow), 7FC0, 7FC0, 0000 (FTZ). MUL sign: (C000, 4040) -> C0C0.
- Handshake:
  - start pulsed again at T+2 with different operands -> ignored; the first result is correct at T+5.
  - start asserted in the DONE cycle -> second done 5 cycles later with the second result.
  - done width is exactly 1 cycle.
- Reset mid-op: assert rst_n=0 at T+3 -> busy, done and result go to 0 immediately. No done follows. A fresh start afterwards completes normally in 5 cycles.
- Hold: after done, change a/b/acc without start for 10 cycles -> result unchanged, done stays 0.
